// File: rtl/period_energy_integrator_if.sv
// Sample/control bundle and result bus for the period energy integrator.
interface period_energy_integrator_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 64,
  parameter int CNT_WIDTH    = 32
);
  logic [SAMPLE_WIDTH-1:0] in_sample;
  logic                    in_valid;
  logic                    int_start;
  logic                    int_stop;
  logic                    clear;
  logic [ACC_WIDTH-1:0]    out_sum_sq;
  logic [ACC_WIDTH-1:0]    out_sum;
  logic [CNT_WIDTH-1:0]    out_count;
  logic [SAMPLE_WIDTH-1:0] out_peak;
  logic                    out_overflow;
  logic                    out_valid;
  logic                    busy;

  modport master (
    output in_sample, in_valid, int_start, int_stop, clear,
    input  out_sum_sq, out_sum, out_count, out_peak, out_overflow, out_valid, busy
  );

  modport slave (
    input  in_sample, in_valid, int_start, int_stop, clear,
    output out_sum_sq, out_sum, out_count, out_peak, out_overflow, out_valid, busy
  );
endinterface

// File: rtl/period_energy_integrator.sv
// Integrates sum, sum of squares, count and peak |x| of a signed sample stream
// over one zero-crossing window and publishes the result with a one-cycle strobe.
// Optional peak tracker: define PERIOD_ENERGY_PEAK_EN; otherwise out_peak is 0.
//
// state | meaning
// IDLE  | waiting for int_start
// ACCUM | window open, accumulating valid samples
// DONE  | window closed; result is published one cycle later
//
// ACC_WIDTH must be at least 2*SAMPLE_WIDTH so one square always fits.
module period_energy_integrator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 64,
  parameter int CNT_WIDTH    = 32
) (
  input logic                   clk,
  input logic                   rst,
  period_energy_integrator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state, state_nx;
  logic   load, add, pend, publish;

  logic [ACC_WIDTH-1:0] acc_sq, acc_sum, nx_sq, nx_sum, base_sq, base_sum;
  logic [CNT_WIDTH-1:0] acc_cnt, nx_cnt, base_cnt;
  logic                 acc_ovf, nx_ovf, base_ovf;

  logic signed [SAMPLE_WIDTH-1:0]   smp;
  logic signed [2*SAMPLE_WIDTH-1:0] smp_w, sq_s;
  logic        [2*SAMPLE_WIDTH-1:0] sq_u;
  logic        [ACC_WIDTH:0]        sq_ext, sq_tmp;
  logic signed [ACC_WIDTH:0]        smp_x, sum_tmp;
  logic        [CNT_WIDTH:0]        cnt_tmp;

  assign smp   = $signed(bus.in_sample);
  assign smp_w = smp;
  assign sq_s  = smp_w * smp_w;
  assign sq_u  = sq_s;
  assign smp_x = smp;

  // The delayed publish lets the result land exactly two edges after DONE is entered.
  assign publish  = pend && !bus.clear;
  assign bus.busy = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state; clear beats start, start beats stop
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    add      = 1'b0;
    if (bus.clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.int_start) begin
            state_nx = ACCUM;
            load     = 1'b1;
          end
        end
        ACCUM: begin
          if (bus.int_start) begin
            load = 1'b1;
          end else begin
            add = 1'b1;
            if (bus.int_stop) state_nx = DONE;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Saturating accumulation of the current sample onto either zero (new window) or the running totals
  always_comb begin
    base_sq  = load ? '0 : acc_sq;
    base_sum = load ? '0 : acc_sum;
    base_cnt = load ? '0 : acc_cnt;
    base_ovf = load ? 1'b0 : acc_ovf;
    sq_ext   = '0;
    sq_ext[2*SAMPLE_WIDTH-1:0] = sq_u;
    sq_tmp   = {1'b0, base_sq} + sq_ext;
    sum_tmp  = $signed({base_sum[ACC_WIDTH-1], base_sum}) + smp_x;
    cnt_tmp  = {1'b0, base_cnt} + (CNT_WIDTH+1)'(1);
    nx_sq    = base_sq;
    nx_sum   = base_sum;
    nx_cnt   = base_cnt;
    nx_ovf   = base_ovf;
    if (bus.in_valid) begin
      if (sq_tmp[ACC_WIDTH]) begin
        nx_sq  = '1;
        nx_ovf = 1'b1;
      end else begin
        nx_sq = sq_tmp[ACC_WIDTH-1:0];
      end
      if (sum_tmp[ACC_WIDTH] != sum_tmp[ACC_WIDTH-1]) begin
        nx_ovf = 1'b1;
        nx_sum = sum_tmp[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        nx_sum = sum_tmp[ACC_WIDTH-1:0];
      end
      if (cnt_tmp[CNT_WIDTH]) begin
        nx_cnt = '1;
        nx_ovf = 1'b1;
      end else begin
        nx_cnt = cnt_tmp[CNT_WIDTH-1:0];
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (!rst || bus.clear) begin
      acc_sq  <= '0;
      acc_sum <= '0;
      acc_cnt <= '0;
      acc_ovf <= 1'b0;
    end else if (load || add) begin
      acc_sq  <= nx_sq;
      acc_sum <= nx_sum;
      acc_cnt <= nx_cnt;
      acc_ovf <= nx_ovf;
    end
  end

  // Result publication: accumulators are frozen through DONE and the following edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend             <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_sum_sq   <= '0;
      bus.out_sum      <= '0;
      bus.out_count    <= '0;
      bus.out_overflow <= 1'b0;
    end else begin
      pend          <= (state == DONE) && !bus.clear;
      bus.out_valid <= publish;
      if (publish) begin
        bus.out_sum_sq   <= acc_sq;
        bus.out_sum      <= acc_sum;
        bus.out_count    <= acc_cnt;
        bus.out_overflow <= acc_ovf;
      end
    end
  end

`ifdef PERIOD_ENERGY_PEAK_EN
  logic [SAMPLE_WIDTH-1:0] acc_peak, base_peak, nx_peak, mag;

  // Magnitude as unsigned, so the most negative sample maps to 2^(SAMPLE_WIDTH-1)
  always_comb begin
    mag       = smp[SAMPLE_WIDTH-1] ? (~bus.in_sample + 1'b1) : bus.in_sample;
    base_peak = load ? '0 : acc_peak;
    nx_peak   = base_peak;
    if (bus.in_valid && (mag > base_peak)) nx_peak = mag;
  end

  // Peak tracker and its published copy
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_peak     <= '0;
      bus.out_peak <= '0;
    end else begin
      if (bus.clear)          acc_peak <= '0;
      else if (load || add)   acc_peak <= nx_peak;
      if (publish) bus.out_peak <= acc_peak;
    end
  end
`else
  assign bus.out_peak = '0;
`endif
endmodule
